// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns RV32I byte/half/word accesses into aligned
// word transactions on a memory without byte enables (sub-word stores use read-modify-write).
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ready_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  // Counter only has to reach TIMEOUT-1; the expiry decision happens in that cycle.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [15:0]       wdata_lo_q, wdata_lo_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic        f3_legal;
  logic        misaligned;
  logic        wd_expire;
  logic [31:0] rd_shift;
  logic [31:0] load_val;
  logic [31:0] merged_w;

  always_comb begin
    f3_legal = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !we_i;
      default:                f3_legal = 1'b0;
    endcase
    misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
  end

  assign wd_expire = (TIMEOUT != 0) && (wdog_q == WD_LAST);

  // Little-endian lane select: the addressed byte/half lands in the low bits.
  assign rd_shift = mem_rdata_i >> {addr_lo_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_val = {24'b0, rd_shift[7:0]};
      3'b101:  load_val = {16'b0, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      logic sb_hit;
      logic sh_hit;
      assign sb_hit = (funct3_q[1:0] == 2'b00) && (addr_lo_q == 2'(gi));
      assign sh_hit = (funct3_q[1:0] == 2'b01) && (addr_lo_q[1] == 1'(gi / 2));
      assign merged_w[gi*8 +: 8] = sb_hit ? wdata_lo_q[7:0] :
                                   sh_hit ? wdata_lo_q[(gi % 2)*8 +: 8] :
                                            mem_rdata_i[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    wdata_lo_d  = wdata_lo_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    wdog_d      = wdog_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d       = we_i;
          funct3_d   = funct3_i;
          addr_lo_d  = addr_i[1:0];
          wdata_lo_d = wdata_i[15:0];
          if (!f3_legal || misaligned) begin
            err_d   = 1'b1;
            rdata_d = 32'b0;
            state_d = RESP;
          end else begin
            err_d      = 1'b0;
            wdog_d     = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = {addr_i[ADDR_W-1:2], 2'b00};
            if (we_i && (funct3_i == 3'b010)) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = wdata_i;
              state_d     = WR;
            end else begin
              mem_we_d = 1'b0;
              state_d  = RD;
            end
          end
        end
      end
      RD: begin
        if (mem_ready_i) begin
          if (!we_q) begin
            rdata_d   = load_val;
            mem_req_d = 1'b0;
            state_d   = RESP;
          end else begin
            mem_we_d    = 1'b1;
            mem_wdata_d = merged_w;
            wdog_d      = '0;
            state_d     = WR;
          end
        end else if (wd_expire) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          rdata_d   = 32'b0;
          state_d   = RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      WR: begin
        if (mem_ready_i || wd_expire) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          rdata_d   = 32'b0;
          err_d     = !mem_ready_i;
          state_d   = RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b0;
      addr_lo_q   <= 2'b0;
      wdata_lo_q  <= 16'b0;
      rdata_q     <= 32'b0;
      err_q       <= 1'b0;
      wdog_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      wdata_lo_q  <= wdata_lo_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      wdog_q      <= wdog_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Stall is gated by reset so every output reads 0 while rst_i is low.
  assign stall_o     = rst_i && (((state_q == IDLE) && req_i) || (state_q == RD) || (state_q == WR));
  assign done_o      = (state_q == RESP);
  assign err_o       = (state_q == RESP) && err_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores against a wait-state memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        err_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'b0;
  logic        mem_ready_i = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o),
    .err_o(err_o), .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    int          nreq;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers after wait_cfg stall cycles per phase, or never when hang is set.
  logic [31:0] mem [0:1023];
  bit          loaded = 1'b0;
  int          wait_cfg = 0;
  bit          hang = 1'b0;
  int          phase_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          req_cyc = 0;

  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'b0;
      mem['h40] = 32'h80FF7F01;
      mem['h41] = 32'hAAAAAAAA;
      mem['hC0] = 32'h11223344;
      loaded = 1'b1;
    end
    if (!rst_i || !mem_req_o) begin
      mem_ready_i = 1'b0;
      phase_cnt   = 0;
    end else begin
      req_cyc++;
      if (!hang && phase_cnt >= wait_cfg) begin
        mem_ready_i = 1'b1;
        phase_cnt   = 0;
        if (mem_we_o) begin
          mem[mem_addr_o[11:2]] = mem_wdata_o;
          wr_cnt++;
        end else begin
          mem_rdata_i = mem[mem_addr_o[11:2]];
          rd_cnt++;
        end
      end else begin
        mem_ready_i = 1'b0;
        phase_cnt++;
      end
    end
  end

  // Monitor: tracks accept->done latency and memory traffic, pops the scoreboard on done_o.
  bit   busy = 1'b0;
  int   cyc = 0;
  int   rd0 = 0;
  int   wr0 = 0;
  int   rq0 = 0;
  int   viol = 0;
  int   txn = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_i) begin
      busy = 1'b0;
    end else begin
      if ((mem_req_o && !stall_o) || (done_o && stall_o) ||
          (mem_req_o && (mem_addr_o[1:0] != 2'b00)) || (mem_addr_o[31:12] != 20'b0))
        viol++;
      if (busy) begin
        cyc++;
        if (done_o) begin
          busy = 1'b0;
          txn++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_done: txn %0d got done_o with empty scoreboard", txn);
          end else begin
            e = exp_q.pop_front();
            $display("txn %0d: rdata=%h err=%b lat=%0d rd=%0d wr=%0d reqcyc=%0d",
                     txn, rdata_o, err_o, cyc, rd_cnt - rd0, wr_cnt - wr0, req_cyc - rq0);
            chk("rdata", rdata_o, e.rdata);
            chk("err", 32'(err_o), 32'(e.err));
            chk("latency", cyc, e.lat);
            chk("reads", rd_cnt - rd0, e.nrd);
            chk("writes", wr_cnt - wr0, e.nwr);
            chk("req_cycles", req_cyc - rq0, e.nreq);
          end
        end
      end else if (req_i) begin
        busy = 1'b1;
        cyc  = 1;
        rd0  = rd_cnt;
        wr0  = wr_cnt;
        rq0  = req_cyc;
        if (!stall_o) viol++;
      end
    end
  end

  // Called just after a rising edge with the DUT idle; returns just after the edge following done_o.
  task automatic op(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                    input int wt, input logic [31:0] er, input logic ee, input int el,
                    input int enr, input int enw, input int enq);
    exp_t x;
    bit   got;
    x.rdata = er; x.err = ee; x.lat = el; x.nrd = enr; x.nwr = enw; x.nreq = enq;
    exp_q.push_back(x);
    wait_cfg = wt;
    we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd; req_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = done_o;
    end
    n_vec++;
    if (!got) begin
      n_mis++;
      $display("FAIL done_timeout: no done_o for addr %h funct3 %b we %b", a, f3, we);
      void'(exp_q.pop_back());
    end
    @(posedge clk);
    #1;
    req_i = 1'b0;
  endtask

  initial begin
    bit got;
    rst_i = 1'b0; req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b0; addr_i = 32'b0; wdata_i = 32'b0;
    #12;
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_mem_we", 32'(mem_we_o), 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    req_i = 1'b0;
    @(posedge clk); #1; rst_i = 1'b1;
    @(posedge clk); #1;

    // Loads from word 0x80FF7F01 at 0x100
    op(0, 3'b000, 32'h102, 32'h0, 0, 32'hFFFFFFFF, 1'b0, 3, 1, 0, 1);
    op(0, 3'b100, 32'h102, 32'h0, 0, 32'h000000FF, 1'b0, 3, 1, 0, 1);
    op(0, 3'b001, 32'h102, 32'h0, 0, 32'hFFFF80FF, 1'b0, 3, 1, 0, 1);
    op(0, 3'b101, 32'h100, 32'h0, 0, 32'h00007F01, 1'b0, 3, 1, 0, 1);
    op(0, 3'b000, 32'h103, 32'h0, 0, 32'hFFFFFF80, 1'b0, 3, 1, 0, 1);
    op(0, 3'b010, 32'h100, 32'h0, 0, 32'h80FF7F01, 1'b0, 3, 1, 0, 1);
    op(0, 3'b000, 32'h101, 32'h0, 1, 32'h0000007F, 1'b0, 4, 1, 0, 2);

    // sh into upper half of 0xAAAAAAAA with two wait states per phase
    op(1, 3'b001, 32'h106, 32'h1234ABCD, 2, 32'h0, 1'b0, 8, 1, 1, 6);
    chk("mem_104_after_sh", mem['h41], 32'hABCDAAAA);

    op(1, 3'b010, 32'h200, 32'hDEADBEEF, 0, 32'h0, 1'b0, 3, 0, 1, 1);
    chk("mem_200_after_sw", mem['h80], 32'hDEADBEEF);
    op(1, 3'b000, 32'h201, 32'h12345655, 0, 32'h0, 1'b0, 4, 1, 1, 2);
    chk("mem_200_after_sb", mem['h80], 32'hDEAD55EF);
    op(0, 3'b010, 32'h200, 32'h0, 0, 32'hDEAD55EF, 1'b0, 3, 1, 0, 1);

    // Misaligned and illegal encodings: two-cycle error, no memory traffic
    op(0, 3'b010, 32'h203, 32'h0, 0, 32'h0, 1'b1, 2, 0, 0, 0);
    op(0, 3'b001, 32'h101, 32'h0, 0, 32'h0, 1'b1, 2, 0, 0, 0);
    op(0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1'b1, 2, 0, 0, 0);
    op(1, 3'b100, 32'h100, 32'h1, 0, 32'h0, 1'b1, 2, 0, 0, 0);
    chk("mem_100_untouched", mem['h40], 32'h80FF7F01);

    // Watchdog: memory never answers
    hang = 1'b1;
    op(0, 3'b010, 32'h100, 32'h0, 0, 32'h0, 1'b1, 6, 0, 0, 4);
    hang = 1'b0;
    op(0, 3'b010, 32'h100, 32'h0, 0, 32'h80FF7F01, 1'b0, 3, 1, 0, 1);

    // Reset while the sb write phase is still waiting on memory
    wait_cfg = 2;
    we_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h301; wdata_i = 32'h99; req_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = mem_we_o && mem_req_o;
    end
    chk("reach_wr_phase", 32'(got), 32'h1);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("mid_rst_mem_we", 32'(mem_we_o), 32'h0);
    chk("mid_rst_stall", 32'(stall_o), 32'h0);
    chk("mid_rst_done", 32'(done_o), 32'h0);
    req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_i = 1'b1;
    @(posedge clk); #1;
    chk("mem_300_no_partial_write", mem['hC0], 32'h11223344);
    op(0, 3'b010, 32'h300, 32'h0, 0, 32'h11223344, 1'b0, 3, 1, 0, 1);

    repeat (2) @(posedge clk);
    chk("protocol_violations", viol, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine between the EX/MEM pipeline register and the word-wide Data_Memory.
- Converts RV32I lb/lh/lw/lbu/lhu/sb/sh/sw into aligned 32-bit word accesses.
- Data_Memory has no byte enables, so sub-word stores are done as read-modify-write.
- Raises stall_o to freeze the pipeline while a transaction is in flight; checks alignment and a memory-response watchdog.

Parameters:
ADDR_W, 32, byte-address width
TIMEOUT, 255, max cycles waiting for mem_ready_i per memory phase; 0 disables watchdog

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
req_i  input  1  pipeline requests a memory op; held stable with operands until done_o
we_i  input  1  1 = store, 0 = load
funct3_i  input  3  RV32I width/sign code
addr_i  input  ADDR_W  byte address
wdata_i  input  32  store data (low bits used for sb/sh)
rdata_o  output  32  extended load result, valid when done_o=1
done_o  output  1  one-cycle completion pulse
err_o  output  1  qualifies done_o: misaligned, illegal funct3 or timeout
stall_o  output  1  pipeline hold
mem_req_o  output  1  memory access request
mem_we_o  output  1  memory write enable
mem_addr_o  output  ADDR_W  word address, bits[1:0]=0
mem_wdata_o  output  32  word to write
mem_rdata_i  input  32  word read
mem_ready_i  input  1  memory completes current phase this cycle

Behaviour:
- Reset, asynchronous: state=IDLE, watchdog=0.
- All outputs 0 during reset, including mem_req_o, which drops immediately even mid-transaction.
- No partial write survives a reset after the write phase has not yet completed.
- States: IDLE, RD, WR, RESP.
- IDLE, req_i=1: latch we/funct3/addr/wdata and check legality.
- Legal funct3: loads 000,001,010,100,101; stores 000,001,010.
- Misaligned: half-word with addr[0]=1; word with addr[1:0]!=0.
- Illegal or misaligned -> RESP with err_o=1 and no memory access.
- Otherwise: load or sb/sh -> RD; sw -> WR.
- RD: mem_req_o=1, mem_we_o=0, mem_addr_o={addr[ADDR_W-1:2],2'b00}.
- On mem_ready_i=1 in RD:
  - load: extract byte/half at addr[1:0] (little-endian), sign-extend (lb/lh) or zero-extend (lbu/lhu), register into rdata_o, -> RESP.
  - sb/sh: merge wdata low byte/half into the read word at the addressed lane, -> WR.
- WR: mem_req_o=1, mem_we_o=1, mem_wdata_o = merged word (sb/sh) or wdata (sw). On mem_ready_i=1 -> RESP.
- RESP: done_o=1 for exactly one cycle, then -> IDLE.
- rdata_o holds its value until the next load completes; it is 0 after a store or error.
- mem_ready_i may be high in the first RD/WR cycle (zero wait). It is ignored outside RD/WR.
- mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are registered and held stable until ready is sampled.
- Watchdog counts cycles in RD/WR; it clears on each phase entry.
- Watchdog expiry when count reaches TIMEOUT without ready: drop mem_req_o, -> RESP with err_o=1, and skip WR if in RD.
- stall_o = (IDLE && req_i) || RD || WR. Combinational, so the pipeline freezes in the request cycle.
- stall_o=0 in RESP; the pipeline advances on the done_o edge.
- req_i seen in RESP is ignored; it is accepted at the following IDLE cycle.
- Back-to-back requests therefore cost one IDLE bubble.
- Latency with zero-wait memory: lw/lb 3 cycles accept->done; sw 3; sb/sh 4; error 2.

Test Plan:
- Memory word 0x80FF7F01 at 0x100. lb at 0x102 -> rdata_o=0xFFFFFFFF. lbu at 0x102 -> 0x000000FF. lh at 0x102 -> 0xFFFF80FF. Each has done_o after 3 cycles and err_o=0.
- sh wdata=0x1234ABCD at 0x106, word 0xAAAAAAAA, ready delayed 2 cycles per phase -> one read then write 0xABCDAAAA at 0x104; stall_o high throughout RD/WR.
- sw 0xDEADBEEF at 0x200, zero wait -> exactly one write phase, no read phase; done_o on cycle 3.
- lw at 0x203 and lh at 0x101 -> err_o=1 with done_o on cycle 2; mem_req_o never asserted.
- TIMEOUT=4, mem_ready_i held 0 on lw -> mem_req_o high 4 cycles, then done_o+err_o, back to IDLE.
- rst_i low during the WR phase of sb -> mem_req_o/stall_o 0 immediately. After release, state=IDLE and a fresh lw completes normally.
